// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_filt_2_if.sv
// Signal bundle for the debounced NOR3 detector: raw inputs and CLR in, filtered outputs and debug state out.
// FLAG/CLR handshake: FLAG is a sticky request and CLR is its acknowledge; CLR is honoured on any edge without a ZN_RISE.
interface gf180mcu_fd_sc_mcu7t5v0__nor3_filt_2_if;
    logic       A1;
    logic       A2;
    logic       A3;
    logic       CLR;
    logic       ZN;
    logic       ZN_RISE;
    logic       FLAG;
    logic       dbg_pend;
    logic [3:0] dbg_cnt;

    modport master (
        output A1, A2, A3, CLR,
        input  ZN, ZN_RISE, FLAG, dbg_pend, dbg_cnt
    );

    modport slave (
        input  A1, A2, A3, CLR,
        output ZN, ZN_RISE, FLAG, dbg_pend, dbg_cnt
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_filt_2.sv
// Registered, glitch-filtered ~(A1|A2|A3) with rise pulse and sticky flag.
// Define GF180MCU_FD_SC_MCU7T5V0_NOR3_FILT_SYNC_EN to insert the 2-flop input synchroniser.
module gf180mcu_fd_sc_mcu7t5v0__nor3_filt_2 #(
    parameter int unsigned DEPTH = 3
) (
    input logic CLK,
    input logic R,
    gf180mcu_fd_sc_mcu7t5v0__nor3_filt_2_if.slave bus
);
    localparam logic [3:0] CNT_LAST = 4'(DEPTH - 1);

    typedef enum logic {
        AGREE = 1'b0,
        PEND  = 1'b1
    } state_t;

    logic       nraw;
    logic       s;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       zn_q, zn_d;
    logic       rise_q, rise_d;
    logic       flag_q, flag_d;

    assign nraw = ~(bus.A1 | bus.A2 | bus.A3);

`ifdef GF180MCU_FD_SC_MCU7T5V0_NOR3_FILT_SYNC_EN
    logic s1, s2;

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= nraw;
            s2 <= s1;
        end
    end

    assign s = s2;
`else
    assign s = nraw;
`endif

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state_q <= AGREE;
            cnt_q   <= 4'd0;
            zn_q    <= 1'b0;
            rise_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zn_q    <= zn_d;
            rise_q  <= rise_d;
            flag_q  <= flag_d;
        end
    end

    // A disagreement must persist for DEPTH consecutive samples; any agreeing sample restarts the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zn_d    = zn_q;
        case (state_q)
            AGREE: begin
                if (s != zn_q) begin
                    if (cnt_q == CNT_LAST) begin
                        zn_d = s;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (s == zn_q) begin
                    cnt_d   = 4'd0;
                    state_d = AGREE;
                end else if (cnt_q == CNT_LAST) begin
                    zn_d    = s;
                    cnt_d   = 4'd0;
                    state_d = AGREE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = AGREE;
            end
        endcase
        rise_d = zn_d & ~zn_q;
        // A pending rise wins over a simultaneous clear.
        flag_d = rise_q | (flag_q & ~bus.CLR);
    end

    assign bus.ZN       = zn_q;
    assign bus.ZN_RISE  = rise_q;
    assign bus.FLAG     = flag_q;
    assign bus.dbg_pend = (state_q == PEND);
    assign bus.dbg_cnt  = cnt_q;
endmodule
